bcd_ascii_serial_converter: RTL

//  Parametrised, iterative (shift-add-3) binary-to-BCD converter with ASCII output.

---
 rtl/bcd_conv_pkg.sv | 19 +
 rtl/bcd_add3_adjust.sv | 7 +
 rtl/bcd_ascii_serial_converter.sv | 115 +++++++++++
 3 files changed

// File: rtl/bcd_conv_pkg.sv
// bcd_conv_pkg: shared constants, FSM state type and digit-count helper for the BCD/ASCII converter.
package bcd_conv_pkg;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
  function automatic int min_digits(input int width);
    longint unsigned v;
    int n;
    v = (64'd1 << width) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 0) begin
        n++;
        v = v / 64'd10;
      end
    end
    return (n < 1) ? 1 : n;
  endfunction
endpackage

// File: rtl/bcd_add3_adjust.sv
// bcd_add3_adjust: one shift-add-3 digit correction step (d >= 5 ? d + 3 : d).
module bcd_add3_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bcd_ascii_serial_converter.sv
// bcd_ascii_serial_converter: iterative binary-to-BCD converter with ASCII digits, one input bit per cycle.
// Optional leading-zero blanking in ascii_out when BCD_LEADING_BLANK_EN is defined.
module bcd_ascii_serial_converter
  import bcd_conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [8*DIGITS-1:0]   ascii_out
);
  localparam int CW = $clog2(WIDTH);
`ifdef BCD_LEADING_BLANK_EN
  localparam logic [8*DIGITS-1:0] ASCII_RST = {{(DIGITS-1){ASCII_SPACE}}, ASCII_ZERO};
`else
  localparam logic [8*DIGITS-1:0] ASCII_RST = {DIGITS{ASCII_ZERO}};
`endif
  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("bcd_ascii_serial_converter: WIDTH %0d outside 4..32", WIDTH);
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("bcd_ascii_serial_converter: DIGITS %0d too small for WIDTH %0d", DIGITS, WIDTH);
  end
  bcd_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d, shift_nx;
  logic [4*DIGITS-1:0] scratch_q, scratch_d, scratch_nx, adj;
  logic [4*DIGITS+WIDTH-1:0] cat_nx;
  logic busy_q, busy_d, done_q, done_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [8*DIGITS-1:0] ascii_q, ascii_d, ascii_nx;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3_adjust u_adj (.din(scratch_q[4*g+:4]), .dout(adj[4*g+:4]));
  end
  assign cat_nx = {adj, shift_q} << 1;
  assign scratch_nx = cat_nx[4*DIGITS+WIDTH-1:WIDTH];
  assign shift_nx = cat_nx[WIDTH-1:0];
`ifdef BCD_LEADING_BLANK_EN
  logic lead;
  always_comb begin
    ascii_nx = '0;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead = lead && (scratch_nx[4*i+:4] == 4'd0) && (i != 0);
      ascii_nx[8*i+:8] = lead ? ASCII_SPACE : ASCII_ZERO + {4'b0, scratch_nx[4*i+:4]};
    end
  end
`else
  always_comb begin
    ascii_nx = '0;
    for (int i = 0; i < DIGITS; i++) ascii_nx[8*i+:8] = ASCII_ZERO + {4'b0, scratch_nx[4*i+:4]};
  end
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    scratch_d = scratch_q;
    busy_d = busy_q;
    done_d = 1'b0;
    bcd_d = bcd_q;
    ascii_d = ascii_q;
    if (state_q == SHIFT) begin
      shift_d = shift_nx;
      scratch_d = scratch_nx;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d = DONE;
        busy_d = 1'b0;
        done_d = 1'b1;
        bcd_d = scratch_nx;
        ascii_d = ascii_nx;
      end
    end else if (start) begin
      state_d = SHIFT;
      shift_d = bin_in;
      scratch_d = '0;
      cnt_d = CW'(WIDTH - 1);
      busy_d = 1'b1;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      scratch_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q <= '0;
      ascii_q <= ASCII_RST;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      scratch_q <= scratch_d;
      busy_q <= busy_d;
      done_q <= done_d;
      bcd_q <= bcd_d;
      ascii_q <= ascii_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign bcd_out = bcd_q;
  assign ascii_out = ascii_q;
endmodule
